// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: circular buffer of {pc, instr}
// pairs with valid/ready on both sides, synchronous reset and flush.
`timescale 1ns/1ps
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]    pc_mem_q    [DEPTH];
    logic [31:0]    instr_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    // Handshake qualifiers depend on registered count only.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed phases followed by random traffic.
`timescale 1ns/1ps
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, out_ready;
    logic [31:0]     in_pc, in_instr;
    logic            in_ready, out_valid;
    logic [31:0]     out_pc, out_instr;
    logic [PTR_W:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    word_t sb[$];
    int    mcount  = 0;
    bit    started = 1'b0;

    logic [31:0] fpc [4] = '{32'h0004_0000, 32'h0004_0004, 32'h0004_0008, 32'h0004_000C};
    logic [31:0] fin [4] = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'hAC0A_0000};

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ideal FIFO of accepted words plus an occupancy count.
    always @(posedge clk) begin
        bit acc, pp;
        if (rst) begin
            sb.delete();
            mcount  = 0;
            started = 1'b1;
        end else if (started) begin
            if (flush) begin
                sb.delete();
                mcount = 0;
            end else begin
                acc = in_valid && (mcount != DEPTH);
                pp  = out_ready && (mcount != 0);
                if (acc) sb.push_back({in_pc, in_instr});
                mcount = mcount + int'(acc) - int'(pp);
            end
        end
    end

    // Monitor: sampled mid-cycle, pops the scoreboard on each consumed head word.
    always @(negedge clk) begin
        word_t w;
        if (started) begin
            chk("count",     64'(count),     64'(mcount));
            chk("in_ready",  64'(in_ready),  64'(mcount != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(mcount != 0));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t",
                             {out_pc, out_instr}, $time);
                end else begin
                    w = sb.pop_front();
                    chk("head_word", {out_pc, out_instr}, w);
                end
            end else if (!out_valid) begin
                chk("idle_nop", {out_pc, out_instr}, 64'h0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();

        // Fill to DEPTH, then offer a fifth word that must be refused.
        for (int i = 0; i < 4; i++) push_word(fpc[i], fin[i]);
        in_valid = 1'b1; in_pc = 32'h0004_0010; in_instr = 32'h1234_5678;
        repeat (2) cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();
        out_ready = 1'b0;

        // Streaming at one word per cycle.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_pc    = 32'h0004_0000 + 32'(4 * i);
            in_instr = $urandom;
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b0;

        // Full with simultaneous pop; fetch holds its word until accepted.
        for (int i = 0; i < 4; i++) push_word(32'h0004_0020 + 32'(4 * i), $urandom);
        in_valid = 1'b1; in_pc = 32'h0004_0200; in_instr = 32'hDEAD_0001; out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();
        out_ready = 1'b0;

        // Flush with push and pop pending at count=3.
        for (int i = 0; i < 3; i++) push_word(32'h0004_0040 + 32'(4 * i), $urandom);
        in_valid = 1'b1; in_pc = 32'h0004_0050; in_instr = 32'hBAD0_0000;
        out_ready = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0; out_ready = 1'b0;
        push_word(32'h0004_0100, 32'h2008_0100);
        out_ready = 1'b1;
        repeat (3) cyc();
        out_ready = 1'b0;

        // Flush on an empty queue, twice in a row.
        flush = 1'b1;
        repeat (2) cyc();
        flush = 1'b0;

        // Reset together with flush at count=2.
        for (int i = 0; i < 2; i++) push_word(32'h0004_0060 + 32'(4 * i), $urandom);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h0004_0070; out_ready = 1'b1;
        cyc();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        push_word(32'h0004_0300, 32'h2008_0300);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            rst       = ($urandom % 60) == 0;
            in_pc     = $urandom;
            in_instr  = $urandom;
            cyc();
        end

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the instruction-fetch stage and the decode stage.
- Captures {PC, instruction} pairs produced by fetch and presents them to decode in order.
- Uses valid/ready handshakes on both sides.
- Absorbs decode stalls without losing fetched words, and discards all buffered words on a control-flow flush (taken branch/jump).

Parameters:
- DEPTH, 4, number of {PC, instruction} entries held; must be a power of two, 2..16.
- PTR_W, 2, pointer width, equal to log2(DEPTH); must be set consistently with DEPTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all entries (branch/jump redirect); synchronous.
- in_valid  input  1  fetch presents a word this cycle.
- in_pc  input  32  byte address of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  queue can accept a word this cycle.
- out_valid  output  1  head entry valid for decode.
- out_pc  output  32  PC of head entry.
- out_instr  output  32  instruction of head entry.
- out_ready  input  1  decode consumes the head entry this cycle.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {pc[31:0], instr[31:0]}, addressed by wr_ptr and rd_ptr (PTR_W bits, natural wrap DEPTH-1 -> 0). count is a separate register.
- Reset (rst=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs settle to in_ready=1, out_valid=0, out_pc=0, out_instr=32'h0000_0000 (NOP).
  - Storage contents are don't-care.
  - Reset overrides flush and all handshakes in the same cycle.
- in_ready = (count != DEPTH). It is a function of registered state only; there is no combinational path from out_ready to in_ready.
- Push = in_valid && in_ready.
  - Writes {in_pc, in_instr} at wr_ptr and increments wr_ptr.
  - When in_ready=0, in_valid is ignored and the word is not stored. Fetch must hold its PC/instruction.
- out_valid = (count != 0).
- out_pc/out_instr = entry at rd_ptr when count != 0; otherwise 0 and 32'h0 (NOP).
- Pop = out_valid && out_ready: increments rd_ptr. When out_valid=0, out_ready is ignored.
- Latency:
  - A word pushed at edge N is visible on out_* after edge N (1 cycle, no fall-through).
  - Throughput is 1 word/cycle on both sides.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, in_ready=0, so there is no push; a pop in that cycle makes in_ready=1 the next cycle.
  - When count=1, push and pop together: the new word becomes head next cycle and out_valid stays 1.
- count update: +1 on push only, -1 on pop only, unchanged otherwise.
- Flush (flush=1, rst=0):
  - Next state is wr_ptr=rd_ptr=0, count=0.
  - Any push or pop in the same cycle is discarded; the incoming word is dropped.
  - Next cycle: out_valid=0, out_instr=NOP, in_ready=1.
- Flush while empty: no visible change.
- Consecutive flush cycles: the queue remains empty.
- Ordering: strict FIFO, no reordering, no duplication.
- Full/empty distinction comes from count, not from pointer equality.
- Reset mid-operation (any fill level, any handshake state): all entries are lost and the queue is empty on the next cycle, identical to a power-on reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 with in_valid=0. Required: out_valid=0, out_instr=0, out_pc=0, in_ready=1, count=0 every cycle.
- Fill and drain (DEPTH=4), out_ready=0: push PC 0x0004_0000, 0x0004_0004, 0x0004_0008, 0x0004_000C with instrs 0x2008_0005, 0x2009_0003, 0x0109_5020, 0xAC0A_0000.
  - Required: count goes 1,2,3,4, then in_ready=0. A 5th word (0x0004_0010) is not accepted.
  - Then set out_ready=1. Required: the 4 words appear in order, one per cycle, then out_valid=0 and count=0.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles, PC incrementing by 4 from 0x0004_0000. Required:
  - out_pc lags in_pc by exactly 1 cycle.
  - count stays 1 after the first push.
  - No word is lost or duplicated.
- Full with simultaneous pop: from count=4, assert out_ready=1 and in_valid=1. Required:
  - No push in that cycle, count becomes 3.
  - in_ready=1 next cycle, and the next push is accepted with count back to 4.
- Flush: with count=3 and a push plus pop asserted in the same cycle, pulse flush=1. Required:
  - Next cycle count=0, out_valid=0, out_instr=0, in_ready=1.
  - The next word pushed (PC 0x0004_0100) is the first one popped.
- Reset mid-stream: with count=2 and flush=1 in the same cycle, assert rst=1. Required: next cycle count=0, out_valid=0, pointers 0. The first word pushed after reset is the first one popped.
